instruction_fetch_unit: RTL and testbench

//  Requester side of the instruction memory read interface. Owns the PC and issues word

---
 rtl/instruction_fetch_unit.sv | 94 +++++++++
 tb/tb_instruction_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner issuing in-order imem word reads, buffering {pc,instr} for decode.
//  Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr  read request to the instruction memory (held until accepted)
//   imem_rsp_valid, imem_rsp_data    in-order read responses, never back-pressured
//   redirect_valid, redirect_pc      taken branch/jump: flush buffer, drop in-flight data, refetch
//   if_valid/ready, if_instr, if_pc, if_pc_plus4  head of the fetch buffer toward decode
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MAX_OUT = 2,
  parameter int FB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);
  localparam int FAW = FB_DEPTH > 1 ? $clog2(FB_DEPTH) : 1;
  localparam int QAW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(FB_DEPTH + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
  localparam logic [CW-1:0] FB_FULL = CW'(FB_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FB_DEPTH);
  localparam logic [FAW-1:0] FB_LAST = FAW'(FB_DEPTH - 1);
  localparam logic [QAW-1:0] Q_LAST = QAW'(MAX_OUT - 1);
  logic [31:0] pc;
  logic [CW-1:0] out_cnt, drop_cnt, fb_cnt;
  logic [FAW-1:0] fb_rd, fb_wr;
  logic [QAW-1:0] q_rd, q_wr;
  logic [31:0] q_pc [MAX_OUT];
  logic [31:0] fb_pc [FB_DEPTH];
  logic [31:0] fb_instr [FB_DEPTH];
  logic issue, push, pop;
  // Credit: every outstanding read already owns a buffer slot, so responses can never overflow.
  assign imem_req_valid = rst_n && out_cnt < MAX_C && ({1'b0, out_cnt} + {1'b0, fb_cnt}) < DEPTH_C && !redirect_valid;
  assign imem_addr = pc;
  assign issue = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  assign pop = if_valid && if_ready && !redirect_valid;
  assign if_valid = fb_cnt != '0;
  assign if_instr = fb_instr[fb_rd];
  assign if_pc = fb_pc[fb_rd];
  assign if_pc_plus4 = if_pc + 32'd4;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      out_cnt <= '0;
      drop_cnt <= '0;
      fb_cnt <= '0;
      fb_rd <= '0;
      fb_wr <= '0;
      q_rd <= '0;
      q_wr <= '0;
      for (int i = 0; i < FB_DEPTH; i++) begin
        fb_pc[i] <= '0;
        fb_instr[i] <= '0;
      end
    end else begin
      out_cnt <= out_cnt + CW'(issue) - CW'(imem_rsp_valid);
      if (issue) q_wr <= q_wr == Q_LAST ? '0 : q_wr + 1'b1;
      if (imem_rsp_valid) q_rd <= q_rd == Q_LAST ? '0 : q_rd + 1'b1;
      if (redirect_valid) begin
        // Every read still in flight after this cycle belongs to the old path.
        pc <= {redirect_pc[31:2], 2'b00};
        drop_cnt <= out_cnt - CW'(imem_rsp_valid);
        fb_cnt <= '0;
        fb_rd <= '0;
        fb_wr <= '0;
      end else begin
        if (issue) pc <= pc + 32'd4;
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          fb_pc[fb_wr] <= q_pc[q_rd];
          fb_instr[fb_wr] <= imem_rsp_data;
          fb_wr <= fb_wr == FB_LAST ? '0 : fb_wr + 1'b1;
        end
        if (pop) fb_rd <= fb_rd == FB_LAST ? '0 : fb_rd + 1'b1;
        fb_cnt <= fb_cnt + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (issue) q_pc[q_wr] <= pc;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && fb_cnt == FB_FULL));
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized variable-latency memory and decode sink checked against a PC-stream model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int MAX_OUT = 2;
  localparam int FB_DEPTH = 4;
  logic clk = 0, rst_n = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, redirect_valid = 0;
  logic if_valid, if_ready = 0;
  logic [31:0] imem_addr, imem_rsp_data = 0, redirect_pc = 0, if_instr, if_pc, if_pc_plus4;
  typedef struct {logic [31:0] addr; int due;} req_t;
  req_t pend[$];
  int cyc = 0, vectors = 0, errors = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100, ifr_pct = 100;
  int buf_n = 0, drops = 0, delivered = 0, dropped = 0, last_due = 0;
  logic [31:0] exp_req = RESET_PC, exp_if = RESET_PC;
  logic last_valid = 0, saw_wrap = 0;
  always #5 clk = ~clk;
  instruction_fetch_unit #(.RESET_PC(RESET_PC), .MAX_OUT(MAX_OUT), .FB_DEPTH(FB_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  task automatic drive();
    imem_rsp_valid = pend.size() > 0 && pend[0].due <= cyc;
    imem_rsp_data = imem_rsp_valid ? mem(pend[0].addr) : $urandom;
    imem_req_ready = $urandom_range(99) < rdy_pct;
    if_ready = $urandom_range(99) < ifr_pct;
  endtask
  task automatic step();
    int due;
    @(negedge clk);
    last_valid = if_valid;
    vectors++;
    if (if_valid !== (buf_n > 0)) begin errors++; $display("FAIL if_valid: got %b want %b", if_valid, buf_n > 0); end
    vectors++;
    if (pend.size() > MAX_OUT) begin errors++; $display("FAIL out_cnt: got %0d want <= %0d", pend.size(), MAX_OUT); end
    if (imem_req_valid) begin
      vectors++;
      if (imem_addr !== exp_req) begin errors++; $display("FAIL imem_addr: got %h want %h", imem_addr, exp_req); end
    end
    if (redirect_valid) begin
      vectors++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL req_in_redirect: got %b want 0", imem_req_valid); end
    end
    if (if_valid && if_ready && !redirect_valid) begin
      vectors += 3;
      if (if_pc !== exp_if) begin errors++; $display("FAIL if_pc: got %h want %h", if_pc, exp_if); end
      if (if_instr !== mem(exp_if)) begin errors++; $display("FAIL if_instr: got %h want %h", if_instr, mem(exp_if)); end
      if (if_pc_plus4 !== exp_if + 32'd4) begin errors++; $display("FAIL if_pc_plus4: got %h want %h", if_pc_plus4, exp_if + 32'd4); end
      if (if_pc === 32'hFFFF_FFFC && if_pc_plus4 === 32'h0) saw_wrap = 1;
      exp_if += 32'd4;
      buf_n--;
      delivered++;
    end
    if (imem_rsp_valid) begin
      void'(pend.pop_front());
      if (!redirect_valid) begin
        if (drops > 0) begin drops--; dropped++; end
        else buf_n++;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{imem_addr, due});
      exp_req += 32'd4;
    end
    if (redirect_valid) begin
      drops = pend.size();
      buf_n = 0;
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_if = exp_req;
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask
  task automatic do_redirect(input logic [31:0] target);
    redirect_pc = target;
    redirect_valid = 1;
    step();
    redirect_valid = 0;
  endtask
  task automatic apply_reset();
    rst_n = 0;
    redirect_valid = 0;
    imem_rsp_valid = 0;
    #1;
    vectors += 6;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
    if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
    if (if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_if_pc_plus4: got %h want 4", if_pc_plus4); end
    pend.delete();
    buf_n = 0;
    drops = 0;
    exp_req = RESET_PC;
    exp_if = RESET_PC;
    last_due = cyc;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    drive();
  endtask
  task automatic test_reset();
    apply_reset();
  endtask
  task automatic test_stream();
    logic exp_v [6] = '{0, 0, 1, 1, 1, 1};
    int d0;
    lat_min = 1; lat_max = 1; rdy_pct = 100; ifr_pct = 100;
    apply_reset();
    d0 = delivered;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (last_valid !== exp_v[i]) begin errors++; $display("FAIL latency_c%0d: got %b want %b", i, last_valid, exp_v[i]); end
    end
    vectors++;
    if (delivered - d0 != 4) begin errors++; $display("FAIL stream_count: got %0d want 4", delivered - d0); end
  endtask
  task automatic test_backpressure();
    int d0;
    lat_min = 1; lat_max = 1; rdy_pct = 100; ifr_pct = 0;
    apply_reset();
    repeat (10) step();
    #1;
    vectors += 3;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    if (if_valid !== 1'b1) begin errors++; $display("FAIL bp_if_valid: got %b want 1", if_valid); end
    if (buf_n != FB_DEPTH) begin errors++; $display("FAIL bp_buffered: got %0d want %0d", buf_n, FB_DEPTH); end
    ifr_pct = 100;
    d0 = delivered;
    repeat (8) step();
    vectors++;
    if (delivered - d0 < 4) begin errors++; $display("FAIL bp_release: got %0d want >= 4", delivered - d0); end
  endtask
  task automatic test_redirect();
    int d0, n;
    lat_min = 3; lat_max = 3; rdy_pct = 100; ifr_pct = 100;
    apply_reset();
    n = 0;
    while (pend.size() < 2 && n < 20) begin step(); n++; end
    vectors++;
    if (pend.size() != 2) begin errors++; $display("FAIL rd_outstanding: got %0d want 2", pend.size()); end
    dropped = 0;
    d0 = delivered;
    do_redirect(32'h40);
    n = 0;
    while (delivered < d0 + 2 && n < 30) begin step(); n++; end
    vectors += 2;
    if (delivered < d0 + 2) begin errors++; $display("FAIL rd_timeout: got %0d want %0d", delivered - d0, 2); end
    if (dropped != 2) begin errors++; $display("FAIL rd_dropped: got %0d want 2", dropped); end
  endtask
  task automatic test_random();
    lat_min = 1; lat_max = 5; rdy_pct = 50; ifr_pct = 70;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 4) do_redirect($urandom);
      else step();
    end
  endtask
  task automatic test_wrap();
    int d0, n;
    lat_min = 1; lat_max = 2; rdy_pct = 100; ifr_pct = 100;
    saw_wrap = 0;
    d0 = delivered;
    do_redirect(32'hFFFF_FFFB);
    n = 0;
    while (delivered < d0 + 3 && n < 30) begin step(); n++; end
    vectors++;
    if (saw_wrap !== 1'b1) begin errors++; $display("FAIL wrap: got %b want 1", saw_wrap); end
  endtask
  task automatic test_reset_midstream();
    int d0;
    lat_min = 1; lat_max = 1; rdy_pct = 100; ifr_pct = 0;
    apply_reset();
    repeat (12) step();
    vectors++;
    if (buf_n != FB_DEPTH) begin errors++; $display("FAIL mid_full: got %0d want %0d", buf_n, FB_DEPTH); end
    apply_reset();
    ifr_pct = 100;
    d0 = delivered;
    repeat (8) step();
    vectors++;
    if (delivered - d0 < 4) begin errors++; $display("FAIL mid_restart: got %0d want >= 4", delivered - d0); end
  endtask
  initial begin
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_random();
    test_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
